// File: rtl/video_out_pkg.sv
// Shared colour-mode encoding and constants for the video output stage.
package video_out_pkg;

  typedef enum logic [2:0] {
    MODE_WHITE = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_TINT  = 3'd4
  } col_mode_e;

  localparam int         MODE_COUNT = 5;
  localparam int         TINT_SHIFT = 8;
  localparam logic [7:0] TINT_RESET = 8'hFF;

endpackage

// File: rtl/vid_delay_line.sv
// Enable-qualified shift register that keeps colour and timing bits aligned.
module vid_delay_line #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] data_p [PIPE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) data_p[i] <= '0;
    end else if (en) begin
      data_p[0] <= data;
      for (int i = 1; i < PIPE; i++) data_p[i] <= data_p[i-1];
    end
  end

  assign delayed = data_p[PIPE-1];

endmodule

// File: rtl/video_out_stage.sv
// Mono-to-colour video output stage: frame-latched colour mode, aligned
// pixel/timing pipeline on ce_pix, frame counter and breathing LED.
module video_out_stage
  import video_out_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int PIPE  = 2,
  parameter int LED_W = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  video,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       col_mode,
  input  logic [7:0]       tint_r,
  input  logic [7:0]       tint_g,
  input  logic [7:0]       tint_b,
  output logic [OUT_W-1:0] vga_r,
  output logic [OUT_W-1:0] vga_g,
  output logic [OUT_W-1:0] vga_b,
  output logic             vga_de,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             ce_out,
  output logic [15:0]      frame_cnt,
  output logic             led
);

  localparam int BUS_W = 3 + 3 * OUT_W;

  // MSB-first replication; degenerates to LSB truncation when OUT_W <= IN_W.
  function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] pix);
    logic [OUT_W-1:0] res;
    res = '0;
    for (int i = 0; i < OUT_W; i++) res[OUT_W-1-i] = pix[IN_W-1-(i % IN_W)];
    return res;
  endfunction

  function automatic logic [IN_W-1:0] apply_tint(input logic [IN_W-1:0] pix,
                                                 input logic [7:0]      gain);
    return IN_W'(({8'b0, pix} * {{IN_W{1'b0}}, gain}) >> TINT_SHIFT);
  endfunction

  col_mode_e  cfg_mode;
  logic [7:0] cfg_r, cfg_g, cfg_b;
  logic       vs_prev;
  logic       vs_rise;

  assign vs_rise = ce_pix & vsync & ~vs_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_mode  <= MODE_WHITE;
      cfg_r     <= TINT_RESET;
      cfg_g     <= TINT_RESET;
      cfg_b     <= TINT_RESET;
      vs_prev   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (ce_pix) vs_prev <= vsync;
      if (vs_rise) begin
        cfg_mode  <= (col_mode < 3'(MODE_COUNT)) ? col_mode_e'(col_mode) : MODE_WHITE;
        cfg_r     <= tint_r;
        cfg_g     <= tint_g;
        cfg_b     <= tint_b;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Stage p0: colour mapping and blanking mask at pipeline input
  logic [OUT_W-1:0] pix_w, r_p0, g_p0, b_p0;
  logic             de_p0;

  always_comb begin
    de_p0 = ~(hblank | vblank);
    pix_w = widen(video);
    r_p0  = '0;
    g_p0  = '0;
    b_p0  = '0;
    case (cfg_mode)
      MODE_RED:   r_p0 = pix_w;
      MODE_GREEN: g_p0 = pix_w;
      MODE_BLUE:  b_p0 = pix_w;
      MODE_TINT: begin
        r_p0 = widen(apply_tint(video, cfg_r));
        g_p0 = widen(apply_tint(video, cfg_g));
        b_p0 = widen(apply_tint(video, cfg_b));
      end
      default: begin
        r_p0 = pix_w;
        g_p0 = pix_w;
        b_p0 = pix_w;
      end
    endcase
    if (!de_p0) begin
      r_p0 = '0;
      g_p0 = '0;
      b_p0 = '0;
    end
  end

  // Stages p1..pPIPE: aligned delay to the outputs
  logic [BUS_W-1:0] bus_p0, bus_out;

  assign bus_p0 = {de_p0, hsync, vsync, r_p0, g_p0, b_p0};

  vid_delay_line #(
    .WIDTH (BUS_W),
    .PIPE  (PIPE)
  ) u_delay (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      (ce_pix),
    .data    (bus_p0),
    .delayed (bus_out)
  );

  assign {vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b} = bus_out;

  logic [LED_W-1:0] led_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_out  <= 1'b0;
      led_cnt <= '0;
      led     <= 1'b0;
    end else begin
      ce_out  <= ce_pix;
      led_cnt <= led_cnt + LED_W'(1);
      led     <= led_cnt[LED_W-1] ? (led_cnt[LED_W-2 -: 8] >  led_cnt[7:0])
                                  : (led_cnt[LED_W-2 -: 8] <= led_cnt[7:0]);
    end
  end

endmodule

// File: tb/tb_video_out_stage.sv
// Scoreboard bench for video_out_stage: directed pixels push expected outputs,
// a monitor pops and compares on every ce_out, and checks hold between strobes.
module tb_video_out_stage;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ce_pix = 1'b0;
  logic [7:0] video = '0;
  logic [3:0] video4 = '0;
  logic       hblank = 1'b0, vblank = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [2:0] col_mode = '0;
  logic [7:0] tint_r = 8'hFF, tint_g = 8'hFF, tint_b = 8'hFF;

  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_de, vga_hs, vga_vs, ce_out, led;
  logic [15:0] frame_cnt;

  logic [7:0]  up_r, up_g, up_b;
  logic        up_de, up_hs, up_vs, up_ce, up_led;
  logic [15:0] up_frame;

  logic [3:0]  dn_r, dn_g, dn_b;
  logic        dn_de, dn_hs, dn_vs, dn_ce, dn_led;
  logic [15:0] dn_frame;

  int n_total = 0;
  int n_pass  = 0;

  logic [26:0] exp_q[$];
  logic [26:0] last_exp = '0;

  always #5 clk = ~clk;

  video_out_stage #(.IN_W(8), .OUT_W(8), .PIPE(2), .LED_W(27)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .video(video),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .col_mode(col_mode), .tint_r(tint_r), .tint_g(tint_g), .tint_b(tint_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_de(vga_de), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .ce_out(ce_out), .frame_cnt(frame_cnt), .led(led)
  );

  video_out_stage #(.IN_W(4), .OUT_W(8), .PIPE(2), .LED_W(27)) dut_up (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .video(video4),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .col_mode(col_mode), .tint_r(tint_r), .tint_g(tint_g), .tint_b(tint_b),
    .vga_r(up_r), .vga_g(up_g), .vga_b(up_b),
    .vga_de(up_de), .vga_hs(up_hs), .vga_vs(up_vs),
    .ce_out(up_ce), .frame_cnt(up_frame), .led(up_led)
  );

  video_out_stage #(.IN_W(8), .OUT_W(4), .PIPE(2), .LED_W(27)) dut_dn (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .video(video),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .col_mode(col_mode), .tint_r(tint_r), .tint_g(tint_g), .tint_b(tint_b),
    .vga_r(dn_r), .vga_g(dn_g), .vga_b(dn_b),
    .vga_de(dn_de), .vga_hs(dn_hs), .vga_vs(dn_vs),
    .ce_out(dn_ce), .frame_cnt(dn_frame), .led(dn_led)
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endfunction

  // Monitor: pop on each output update, otherwise outputs must hold.
  initial begin
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_exp = '0;
      end else if (ce_out) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("pix", 32'({vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'(e));
          last_exp = e;
        end
      end else begin
        chk("hold", 32'({vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'(last_exp));
      end
    end
  end

  task automatic pix(input logic [7:0] v, input logic [3:0] v4, input logic hb,
                     input logic hs, input logic vs, input logic [2:0] mode,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    video = v; video4 = v4; hblank = hb; hsync = hs; vsync = vs; col_mode = mode;
    ce_pix = 1'b1;
    exp_q.push_back({~hb, hs, vs, er, eg, eb});
    @(posedge clk); #2;
    ce_pix = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic release_reset();
    @(posedge clk); #3;
    reset_n = 1'b1;
    exp_q.push_back('0);
    @(posedge clk); #2;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, ce_out, led}), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_up", 32'({up_r, up_g, up_b, up_de, up_hs, up_vs, up_ce, up_led}), 32'd0);
    chk("rst_dn", 32'({dn_r, dn_g, dn_b, dn_de, dn_hs, dn_vs, dn_ce, dn_led}), 32'd0);
    chk("rst_frames_xw", 32'({up_frame, dn_frame}), 32'd0);
    release_reset();

    // Width conversion in reset-default white mode
    pix(8'hC3, 4'hA, 0, 0, 0, 3'd0, 8'hC3, 8'hC3, 8'hC3);
    pix(8'hC3, 4'hA, 0, 0, 0, 3'd0, 8'hC3, 8'hC3, 8'hC3);
    chk("up_rgb", 32'({up_r, up_g, up_b}), 32'hAAAAAA);
    chk("dn_rgb", 32'({dn_r, dn_g, dn_b}), 32'hCCC);
    chk("xw_de", 32'({up_de, dn_de}), 32'h3);
    chk("frame_none", 32'(frame_cnt), 32'd0);

    // Mid-frame mode changes ignored; value present on the vsync rise wins
    pix(8'h55, 4'h5, 0, 0, 0, 3'd2, 8'h55, 8'h55, 8'h55);
    pix(8'h44, 4'h4, 0, 0, 0, 3'd3, 8'h44, 8'h44, 8'h44);
    pix(8'h40, 4'h4, 0, 0, 1, 3'd2, 8'h40, 8'h40, 8'h40);
    pix(8'h40, 4'h4, 0, 0, 1, 3'd2, 8'h00, 8'h40, 8'h00);
    chk("frame_1", 32'(frame_cnt), 32'd1);

    // Red mode, only after the next qualified rise
    pix(8'h80, 4'h8, 0, 0, 0, 3'd1, 8'h00, 8'h80, 8'h00);
    pix(8'h80, 4'h8, 0, 0, 1, 3'd1, 8'h00, 8'h80, 8'h00);
    pix(8'h80, 4'h8, 0, 0, 1, 3'd1, 8'h80, 8'h00, 8'h00);
    chk("frame_2", 32'(frame_cnt), 32'd2);

    // Blanking masks colour; hsync rides along
    pix(8'h80, 4'h8, 1, 0, 1, 3'd1, 8'h00, 8'h00, 8'h00);
    pix(8'h90, 4'h9, 0, 1, 1, 3'd1, 8'h90, 8'h00, 8'h00);
    vblank = 1'b1;
    ce_pix = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 24'h0});
    @(posedge clk); #2;
    ce_pix = 1'b0;
    vblank = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    // Tint mode
    tint_r = 8'h80; tint_g = 8'h00; tint_b = 8'hFF;
    pix(8'hFF, 4'hF, 0, 0, 0, 3'd4, 8'hFF, 8'h00, 8'h00);
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'hFF, 8'h00, 8'h00);
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'h7F, 8'h00, 8'hFE);
    pix(8'h40, 4'h4, 0, 0, 1, 3'd4, 8'h20, 8'h00, 8'h3F);
    chk("frame_3", 32'(frame_cnt), 32'd3);
    tint_r = 8'h10;
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'h7F, 8'h00, 8'hFE);

    // Frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #2;
    release dut.frame_cnt;
    @(posedge clk); #2;
    chk("frame_preset", 32'(frame_cnt), 32'h0000FFFF);
    pix(8'hFF, 4'hF, 0, 0, 0, 3'd4, 8'h7F, 8'h00, 8'hFE);
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'h7F, 8'h00, 8'hFE);
    chk("frame_wrap", 32'(frame_cnt), 32'd0);
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'h0F, 8'h00, 8'hFE);

    // Asynchronous reset mid-line
    pix(8'hFF, 4'hF, 0, 0, 1, 3'd4, 8'h0F, 8'h00, 8'hFE);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_outputs", 32'({vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs, ce_out}), 32'd0);
    chk("arst_frame", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
    pix(8'h33, 4'h3, 0, 0, 0, 3'd4, 8'h33, 8'h33, 8'h33);
    pix(8'h11, 4'h1, 0, 0, 0, 3'd4, 8'h11, 8'h11, 8'h11);
    pix(8'h00, 4'h0, 1, 0, 0, 3'd4, 8'h00, 8'h00, 8'h00);
    chk("post_rst_frame", 32'(frame_cnt), 32'd0);
    chk("led_on", 32'({led, up_led, dn_led}), 32'h7);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
